// File: rtl/fitness_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fitness_pkg
// Purpose  : Shared types and default sizing for the fitness collector.
//            Holds the collector state encoding, the default lane count,
//            sum width and index width, and the derived fitness width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fitness_pkg;

  localparam int DEF_NUM_OUTPUTS = 8;
  localparam int DEF_SUM_WIDTH   = 32;
  localparam int DEF_IDX_WIDTH   = 8;

  // Summing N lanes of W bits needs W + clog2(N) bits to never wrap.
  localparam int DEF_FIT_WIDTH   = DEF_SUM_WIDTH + $clog2(DEF_NUM_OUTPUTS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCUM    = 2'd1,
    UPDATE   = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

endpackage : fitness_pkg
`default_nettype wire

// File: rtl/fitness_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : fitness_collector_if
// Purpose  : Bundles the upstream handshake, error-sum bus and result outputs
//            of the fitness collector.
// Modports : master - the environment (drives i*, observes o*)
//            slave  - the collector (observes i*, drives o*)
// Options  : FITNESS_PERFECT_DETECT_EN adds oPerfectFound.
// Revision : 1.0 - initial release
// ============================================================================
interface fitness_collector_if #(
  parameter int NUM_OUTPUTS = fitness_pkg::DEF_NUM_OUTPUTS,
  parameter int SUM_WIDTH   = fitness_pkg::DEF_SUM_WIDTH,
  parameter int IDX_WIDTH   = fitness_pkg::DEF_IDX_WIDTH
);
  localparam int FIT_WIDTH = SUM_WIDTH + $clog2(NUM_OUTPUTS);

  // Lane i occupies bits [i*SUM_WIDTH +: SUM_WIDTH].
  logic [NUM_OUTPUTS*SUM_WIDTH-1:0] iErrorSums;
  logic                             iDoneProcessing;
  logic [NUM_OUTPUTS-1:0]           iOutputMask;
  logic [IDX_WIDTH-1:0]             iPopulationSize;

  logic                             oDoneProcessingFeedback;
  logic [FIT_WIDTH-1:0]             oFitness;
  logic                             oFitnessValid;
  logic [IDX_WIDTH-1:0]             oChromIndex;
  logic [IDX_WIDTH-1:0]             oBestIndex;
  logic [FIT_WIDTH-1:0]             oBestFitness;
  logic                             oGenerationDone;
  logic                             oBusy;
`ifdef FITNESS_PERFECT_DETECT_EN
  logic                             oPerfectFound;
`endif

  modport master (
`ifdef FITNESS_PERFECT_DETECT_EN
    input  oPerfectFound,
`endif
    output iErrorSums, iDoneProcessing, iOutputMask, iPopulationSize,
    input  oDoneProcessingFeedback, oFitness, oFitnessValid, oChromIndex,
           oBestIndex, oBestFitness, oGenerationDone, oBusy
  );

  modport slave (
`ifdef FITNESS_PERFECT_DETECT_EN
    output oPerfectFound,
`endif
    input  iErrorSums, iDoneProcessing, iOutputMask, iPopulationSize,
    output oDoneProcessingFeedback, oFitness, oFitnessValid, oChromIndex,
           oBestIndex, oBestFitness, oGenerationDone, oBusy
  );

endinterface : fitness_collector_if
`default_nettype wire

// File: rtl/fitness_best_tracker.sv
`default_nettype none
// ============================================================================
// Module   : fitness_best_tracker
// Purpose  : Tracks the chromosome index within a generation and the best
//            (lowest) fitness seen in the current generation.
// Ports    : clk, rst        - clock, async active-high reset
//            update_en       - one cycle per finished chromosome
//            fitness         - fitness of that chromosome
//            pop_size        - chromosomes per generation (0 acts as 1)
//            chrom_index     - index of the next chromosome to be scored
//            best_index      - index of the best chromosome
//            best_fitness    - best fitness (all-ones after reset)
//            gen_done        - pulse when the generation wraps
// Revision : 1.0 - initial release
// ============================================================================
module fitness_best_tracker #(
  parameter int FIT_WIDTH = fitness_pkg::DEF_FIT_WIDTH,
  parameter int IDX_WIDTH = fitness_pkg::DEF_IDX_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 update_en,
  input  logic [FIT_WIDTH-1:0] fitness,
  input  logic [IDX_WIDTH-1:0] pop_size,
  output logic [IDX_WIDTH-1:0] chrom_index,
  output logic [IDX_WIDTH-1:0] best_index,
  output logic [FIT_WIDTH-1:0] best_fitness,
  output logic                 gen_done
);

  logic [IDX_WIDTH-1:0] last_index;
  logic                 first_of_gen;

  always_comb begin
    last_index   = (pop_size == '0) ? '0 : pop_size - IDX_WIDTH'(1);
    first_of_gen = (chrom_index == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chrom_index  <= '0;
      best_index   <= '0;
      best_fitness <= '1;
      gen_done     <= 1'b0;
    end else begin
      gen_done <= 1'b0;
      if (update_en) begin
        // Strict less-than: ties keep the older entry. The first chromosome
        // always overwrites so a stale best never leaks across generations.
        if (first_of_gen || (fitness < best_fitness)) begin
          best_fitness <= fitness;
          best_index   <= chrom_index;
        end
        // >= also recovers cleanly if the population shrinks mid-generation.
        if (chrom_index >= last_index) begin
          chrom_index <= '0;
          gen_done    <= 1'b1;
        end else begin
          chrom_index <= chrom_index + IDX_WIDTH'(1);
        end
      end
    end
  end

endmodule : fitness_best_tracker
`default_nettype wire

// File: rtl/fitness_collector.sv
`default_nettype none
// ============================================================================
// Module   : fitness_collector
// Purpose  : Captures per-lane error sums, adds the unmasked lanes one per
//            cycle into a non-wrapping fitness value and tracks the best
//            chromosome of each generation.
// Ports    : iClock - clock (rising edge)
//            iReset - asynchronous active-high reset
//            bus    - fitness_collector_if.slave (sums, mask, handshake,
//                     fitness/best/index results, busy)
// Options  : FITNESS_PERFECT_DETECT_EN - adds sticky oPerfectFound, set on a
//            zero fitness; once set, no further captures are accepted.
// Revision : 1.0 - initial release
// ============================================================================
module fitness_collector
  import fitness_pkg::*;
#(
  parameter int NUM_OUTPUTS = DEF_NUM_OUTPUTS,
  parameter int SUM_WIDTH   = DEF_SUM_WIDTH,
  parameter int IDX_WIDTH   = DEF_IDX_WIDTH
) (
  input  logic                iClock,
  input  logic                iReset,
  fitness_collector_if.slave  bus
);

  localparam int FIT_WIDTH  = SUM_WIDTH + $clog2(NUM_OUTPUTS);
  localparam int LANE_WIDTH = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(NUM_OUTPUTS - 1);

  state_t                  state;
  logic [SUM_WIDTH-1:0]    lane_in   [NUM_OUTPUTS];
  logic [SUM_WIDTH-1:0]    sums_q    [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0]  mask_q;
  logic [LANE_WIDTH-1:0]   lane;
  logic [FIT_WIDTH-1:0]    acc;
  logic [SUM_WIDTH-1:0]    lane_term;
  logic                    capture;
  logic                    feedback;
  logic [FIT_WIDTH-1:0]    fitness;
  logic                    fitness_valid;
  logic                    busy;

  for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_unpack
    assign lane_in[i] = bus.iErrorSums[i*SUM_WIDTH +: SUM_WIDTH];
  end

`ifdef FITNESS_PERFECT_DETECT_EN
  logic perfect;
  assign capture           = bus.iDoneProcessing & ~perfect;
  assign bus.oPerfectFound = perfect;
`else
  assign capture = bus.iDoneProcessing;
`endif

  // Works from the captured copy only, so upstream may change after capture.
  always_comb begin
    lane_term = mask_q[lane] ? sums_q[lane] : '0;
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state         <= IDLE;
      for (int i = 0; i < NUM_OUTPUTS; i++) sums_q[i] <= '0;
      mask_q        <= '0;
      lane          <= '0;
      acc           <= '0;
      feedback      <= 1'b0;
      fitness       <= '0;
      fitness_valid <= 1'b0;
      busy          <= 1'b0;
`ifdef FITNESS_PERFECT_DETECT_EN
      perfect       <= 1'b0;
`endif
    end else begin
      feedback      <= 1'b0;
      fitness_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) sums_q[i] <= lane_in[i];
            mask_q   <= bus.iOutputMask;
            lane     <= '0;
            acc      <= '0;
            feedback <= 1'b1;
            busy     <= 1'b1;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc + FIT_WIDTH'(lane_term);
          if (lane == LAST_LANE) begin
            lane  <= '0;
            state <= UPDATE;
          end else begin
            lane <= lane + LANE_WIDTH'(1);
          end
        end
        UPDATE: begin
          fitness       <= acc;
          fitness_valid <= 1'b1;
`ifdef FITNESS_PERFECT_DETECT_EN
          if (acc == '0) perfect <= 1'b1;
`endif
          // A still-high done level belongs to the sums just consumed; wait
          // for it to drop before re-arming.
          if (bus.iDoneProcessing) begin
            state <= WAIT_LOW;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        WAIT_LOW: begin
          if (!bus.iDoneProcessing) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  fitness_best_tracker #(
    .FIT_WIDTH (FIT_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_best_tracker (
    .clk          (iClock),
    .rst          (iReset),
    .update_en    (state == UPDATE),
    .fitness      (acc),
    .pop_size     (bus.iPopulationSize),
    .chrom_index  (bus.oChromIndex),
    .best_index   (bus.oBestIndex),
    .best_fitness (bus.oBestFitness),
    .gen_done     (bus.oGenerationDone)
  );

  assign bus.oDoneProcessingFeedback = feedback;
  assign bus.oFitness                = fitness;
  assign bus.oFitnessValid           = fitness_valid;
  assign bus.oBusy                   = busy;

endmodule : fitness_collector
`default_nettype wire

// File: tb/tb_fitness_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_fitness_collector
// Purpose  : Self-checking bench for fitness_collector (8 lanes, 32-bit sums,
//            8-bit index). Table of directed captures plus hand sequences for
//            held done, reset during accumulation and zero fitness.
// Options  : FITNESS_PERFECT_DETECT_EN enables the perfect-detect sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fitness_collector;
  import fitness_pkg::*;

  localparam int LATENCY = DEF_NUM_OUTPUTS + 2;

  typedef struct {
    logic [255:0] sums;
    logic [7:0]   mask;
    logic [7:0]   pop;
    logic [34:0]  fit;
    logic [34:0]  best;
    logic [7:0]   best_idx;
    logic         gen;
    logic [7:0]   idx_after;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fitness_collector_if bus ();

  fitness_collector dut (
    .iClock (clk),
    .iReset (rst),
    .bus    (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   fb_cnt;
  int   val_cnt;
  int   cyc;
  int   lat;
  logic fb_first;
  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] pack8(input logic [31:0] l0, l1, l2, l3,
                                         input logic [31:0] l4, l5, l6, l7);
    return {l7, l6, l5, l4, l3, l2, l1, l0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called one time unit after a rising edge with the DUT idle. Returns at the
  // first cycle showing oFitnessValid (or after a bounded wait, lat = -1).
  task automatic run_capture(input logic [255:0] s, input logic [7:0] m,
                             input logic [7:0] pop, input bit hold);
    bus.iErrorSums      = s;
    bus.iOutputMask     = m;
    bus.iPopulationSize = pop;
    bus.iDoneProcessing = 1'b1;
    fb_cnt  = 0;
    val_cnt = 0;
    lat     = -1;
    step();
    cyc      = 1;
    fb_first = bus.oDoneProcessingFeedback;
    if (bus.oDoneProcessingFeedback) fb_cnt++;
    if (!hold) bus.iDoneProcessing = 1'b0;
    bus.iErrorSums  = ~s;
    bus.iOutputMask = ~m;
    while (lat < 0 && cyc < 40) begin
      step();
      cyc++;
      if (bus.oDoneProcessingFeedback) fb_cnt++;
      if (bus.oFitnessValid) begin
        val_cnt++;
        lat = cyc;
      end
    end
  endtask

  initial begin
    vecs[0]  = '{pack8(1,2,3,4,5,6,7,8),  8'hFF, 8'd1, 35'd36,  35'd36,  8'd0, 1'b1, 8'd0};
    vecs[1]  = '{pack8(1,2,3,4,5,6,7,8),  8'h0F, 8'd1, 35'd10,  35'd10,  8'd0, 1'b1, 8'd0};
    vecs[2]  = '{{256{1'b1}},             8'hFF, 8'd1, 35'h7_FFFF_FFF8, 35'h7_FFFF_FFF8, 8'd0, 1'b1, 8'd0};
    vecs[3]  = '{pack8(20,0,0,0,0,0,0,0), 8'hFF, 8'd3, 35'd20,  35'd20,  8'd0, 1'b0, 8'd1};
    vecs[4]  = '{pack8(1,1,1,1,1,0,0,0),  8'hFF, 8'd3, 35'd5,   35'd5,   8'd1, 1'b0, 8'd2};
    vecs[5]  = '{pack8(2,3,0,0,0,0,0,0),  8'hFF, 8'd3, 35'd5,   35'd5,   8'd1, 1'b1, 8'd0};
    vecs[6]  = '{pack8(100,7,7,7,7,7,7,7),8'h01, 8'd3, 35'd100, 35'd100, 8'd0, 1'b0, 8'd1};
    vecs[7]  = '{pack8(9,9,9,9,9,9,9,200),8'h80, 8'd3, 35'd200, 35'd100, 8'd0, 1'b0, 8'd2};
    vecs[8]  = '{pack8(9,9,9,3,9,9,9,9),  8'h08, 8'd3, 35'd3,   35'd3,   8'd2, 1'b1, 8'd0};
    vecs[9]  = '{pack8(50,0,0,0,0,0,0,0), 8'hFF, 8'd0, 35'd50,  35'd50,  8'd0, 1'b1, 8'd0};
    vecs[10] = '{pack8(10,10,10,10,10,10,10,30), 8'hFF, 8'd0, 35'd100, 35'd100, 8'd0, 1'b1, 8'd0};

    bus.iErrorSums      = '0;
    bus.iOutputMask     = '0;
    bus.iPopulationSize = 8'd1;
    bus.iDoneProcessing = 1'b1;   // must be ignored while reset is held

    // ---- reset state ----
    #12;
    chk("rst_feedback",   bus.oDoneProcessingFeedback, 0);
    chk("rst_fitness",    bus.oFitness, 0);
    chk("rst_valid",      bus.oFitnessValid, 0);
    chk("rst_chrom_idx",  bus.oChromIndex, 0);
    chk("rst_best_idx",   bus.oBestIndex, 0);
    chk("rst_best_fit",   bus.oBestFitness, 64'h7_FFFF_FFFF);
    chk("rst_gen_done",   bus.oGenerationDone, 0);
    chk("rst_busy",       bus.oBusy, 0);
`ifdef FITNESS_PERFECT_DETECT_EN
    chk("rst_perfect",    bus.oPerfectFound, 0);
`endif
    bus.iDoneProcessing = 1'b0;
    step();
    rst = 1'b0;
    step();

    // ---- table-driven captures ----
    for (int v = 0; v < 11; v++) begin
      run_capture(vecs[v].sums, vecs[v].mask, vecs[v].pop, 1'b0);
      chk($sformatf("v%0d_feedback_first", v), fb_first, 1);
      chk($sformatf("v%0d_latency", v),   lat, LATENCY);
      chk($sformatf("v%0d_fitness", v),   bus.oFitness, vecs[v].fit);
      chk($sformatf("v%0d_best_fit", v),  bus.oBestFitness, vecs[v].best);
      chk($sformatf("v%0d_best_idx", v),  bus.oBestIndex, vecs[v].best_idx);
      chk($sformatf("v%0d_gen_done", v),  bus.oGenerationDone, vecs[v].gen);
      chk($sformatf("v%0d_chrom_idx", v), bus.oChromIndex, vecs[v].idx_after);
      step();
      if (bus.oDoneProcessingFeedback) fb_cnt++;
      chk($sformatf("v%0d_valid_one_cycle", v), bus.oFitnessValid, 0);
      chk($sformatf("v%0d_feedback_count", v),  fb_cnt, 1);
      chk($sformatf("v%0d_idle_busy", v),       bus.oBusy, 0);
    end

    // ---- done held high: single capture, parks in WAIT_LOW ----
    run_capture(pack8(1,2,3,4,5,6,7,8), 8'hFF, 8'd1, 1'b1);
    chk("hold_latency", lat, LATENCY);
    chk("hold_fitness", bus.oFitness, 36);
    while (cyc < 21) begin
      step();
      cyc++;
      if (bus.oDoneProcessingFeedback) fb_cnt++;
      if (bus.oFitnessValid) val_cnt++;
    end
    chk("hold_feedback_count", fb_cnt, 1);
    chk("hold_valid_count",    val_cnt, 1);
    chk("hold_busy",           bus.oBusy, 1);
    chk("hold_wait_low",       dut.state == WAIT_LOW, 1);
    bus.iDoneProcessing = 1'b0;
    step();
    chk("hold_release_busy",   bus.oBusy, 0);

    // ---- reset during ACCUM cycle 4 ----
    bus.iErrorSums      = pack8(1,2,3,4,5,6,7,8);
    bus.iOutputMask     = 8'hFF;
    bus.iDoneProcessing = 1'b1;
    step();
    bus.iDoneProcessing = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    #1;
    chk("midrst_busy",      bus.oBusy, 0);
    chk("midrst_fitness",   bus.oFitness, 0);
    chk("midrst_best_fit",  bus.oBestFitness, 64'h7_FFFF_FFFF);
    chk("midrst_chrom_idx", bus.oChromIndex, 0);
    chk("midrst_state",     dut.state == IDLE, 1);
    step();
    rst = 1'b0;
    fb_cnt  = 0;
    val_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.oDoneProcessingFeedback) fb_cnt++;
      if (bus.oFitnessValid) val_cnt++;
    end
    chk("midrst_no_valid",    val_cnt, 0);
    chk("midrst_no_feedback", fb_cnt, 0);
    run_capture(pack8(1,2,3,4,5,6,7,8), 8'hFF, 8'd1, 1'b0);
    chk("postrst_latency", lat, LATENCY);
    chk("postrst_fitness", bus.oFitness, 36);
    step();

    // ---- zero fitness ----
    run_capture('0, 8'hFF, 8'd1, 1'b0);
    chk("zero_latency", lat, LATENCY);
    chk("zero_fitness", bus.oFitness, 0);
    step();
`ifdef FITNESS_PERFECT_DETECT_EN
    chk("perfect_set", bus.oPerfectFound, 1);
    bus.iErrorSums      = pack8(1,2,3,4,5,6,7,8);
    bus.iDoneProcessing = 1'b1;
    fb_cnt  = 0;
    val_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.oDoneProcessingFeedback) fb_cnt++;
      if (bus.oFitnessValid) val_cnt++;
    end
    chk("perfect_block_feedback", fb_cnt, 0);
    chk("perfect_block_valid",    val_cnt, 0);
    chk("perfect_block_busy",     bus.oBusy, 0);
    chk("perfect_sticky",         bus.oPerfectFound, 1);
    bus.iDoneProcessing = 1'b0;
`else
    run_capture(pack8(1,2,3,4,5,6,7,8), 8'hFF, 8'd1, 1'b0);
    chk("after_zero_latency", lat, LATENCY);
    chk("after_zero_fitness", bus.oFitness, 36);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fitness_collector
`default_nettype wire

// File: doc/fitness_collector.md
FITNESS_COLLECTOR -- requirements
Module: fitness_collector

Interface
REQ-001 The module SHALL have parameter NUM_OUTPUTS, default 8, meaning the number of chromosome output lanes scored.
REQ-002 The module SHALL have parameter SUM_WIDTH, default 32, meaning the width of each per-lane error sum.
REQ-003 The module SHALL have parameter IDX_WIDTH, default 8, meaning the width of the chromosome index within a generation.
REQ-004 The module SHALL have port iClock, input, 1 bit, the single clock; all logic SHALL be on its rising edge.
REQ-005 The module SHALL have port iReset, input, 1 bit, the reset, which is asynchronous and active-high.
REQ-006 The module SHALL have port iErrorSums, input, NUM_OUTPUTS x SUM_WIDTH bits, the per-lane error counts from the processing stage.
REQ-007 The module SHALL have port iDoneProcessing, input, 1 bit, a level meaning the upstream error sums are valid.
REQ-008 The module SHALL have port iOutputMask, input, NUM_OUTPUTS bits, where bit i=1 means lane i counts toward fitness.
REQ-009 The module SHALL have port iPopulationSize, input, IDX_WIDTH bits, the number of chromosomes per generation; a value of 0 SHALL be treated as 1.
REQ-010 The module SHALL have port oDoneProcessingFeedback, output, 1 bit, a one-cycle acknowledge to the upstream stage.
REQ-011 The module SHALL have ports oFitness, output, SUM_WIDTH+clog2(NUM_OUTPUTS) bits, and oFitnessValid, output, 1 bit, a one-cycle strobe.
REQ-012 The module SHALL have ports oChromIndex, oBestIndex (IDX_WIDTH bits), oBestFitness (same width as oFitness), oGenerationDone (1-cycle pulse) and oBusy, all outputs.

Function
REQ-013 The state machine SHALL have states IDLE, ACCUM, UPDATE and WAIT_LOW.
REQ-014 In IDLE with iDoneProcessing=1 at edge k, the module SHALL latch iErrorSums and iOutputMask, clear the accumulator, enter ACCUM, and drive oDoneProcessingFeedback=1 during cycle k+1 only.
REQ-015 ACCUM SHALL add exactly one masked lane per cycle (lane 0 first) for NUM_OUTPUTS cycles, then enter UPDATE.
REQ-016 In UPDATE, oFitness SHALL be loaded and oFitnessValid SHALL pulse for one cycle; the latency from the capture edge to the oFitnessValid cycle is NUM_OUTPUTS+2 cycles.
REQ-017 Accumulation SHALL be zero-extended and SHALL never overflow or wrap; masked lanes SHALL contribute 0.
REQ-018 On the oFitnessValid cycle, oBestFitness and oBestIndex SHALL update if the chromosome is the first of its generation or if the fitness is strictly lower than the stored best; ties SHALL keep the older entry.
REQ-019 oChromIndex SHALL increment after UPDATE and wrap to 0 after iPopulationSize-1; the wrap cycle SHALL coincide with a oGenerationDone pulse.
REQ-020 oBestFitness and oBestIndex SHALL persist through the wrap, and the next generation's first chromosome SHALL overwrite them.
REQ-021 Exiting UPDATE SHALL go to IDLE if iDoneProcessing=0 and otherwise to WAIT_LOW; WAIT_LOW SHALL return to IDLE when iDoneProcessing=0, so that no double capture occurs.
REQ-022 oBusy SHALL be 1 in every state except IDLE.
REQ-023 iErrorSums and iOutputMask changes after capture SHALL NOT affect the current result.

Reset
REQ-024 While iReset=1, the state SHALL be IDLE and all outputs SHALL be 0, except oBestFitness, which SHALL be all-ones.
REQ-025 Reset mid-ACCUM SHALL discard the partial sum, and no oFitnessValid or oDoneProcessingFeedback pulse SHALL follow.

Configuration
REQ-026 With FITNESS_PERFECT_DETECT_EN defined, the module SHALL provide output oPerfectFound, which is set when an UPDATE yields fitness 0, is sticky until reset, and blocks further captures in IDLE.
REQ-027 Without FITNESS_PERFECT_DETECT_EN, the port and logic SHALL be absent, and a zero fitness SHALL be handled like any other value.

Structure
REQ-028 Package fitness_pkg SHALL hold the state enum, the default NUM_OUTPUTS/SUM_WIDTH/IDX_WIDTH constants, and the derived fitness width.
REQ-029 The best-tracking compare/update (REQ-018 to REQ-020) SHALL be a sub-module named fitness_best_tracker; accumulation and the state machine SHALL stay in the top module.

Verification
REQ-030 The bench SHALL apply sums {1,2,3,4,5,6,7,8}, mask 0xFF, hold done -> oFitness=36, valid 10 cycles after capture, feedback exactly once.
REQ-031 The bench SHALL apply the same sums with mask 0x0F -> oFitness=10; then all lanes 0xFFFFFFFF, mask 0xFF -> oFitness=0x7_FFFF_FFF8, no wrap.
REQ-032 The bench SHALL apply population 3 with fitnesses 20, 5, 5 -> best=5, index 1, oGenerationDone with the third result, index back to 0.
REQ-033 The bench SHALL hold iDoneProcessing high 20 cycles after feedback -> one capture only, state held in WAIT_LOW.
REQ-034 The bench SHALL assert iReset during ACCUM cycle 4 -> no valid strobe, all outputs at reset values, and the next capture SHALL be correct.
REQ-035 With FITNESS_PERFECT_DETECT_EN, the bench SHALL apply all-zero sums -> oPerfectFound=1, and the next iDoneProcessing SHALL be ignored.
